// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the direct-mapped data cache.
package dcache_pkg;

   localparam int NUM_LINES = 16;
   localparam int LINE_BITS = 128;
   localparam int OFFSET_W  = 4;
   localparam int INDEX_W   = 4;
   localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
   localparam int WORDS     = LINE_BITS / 32;
   localparam int WSEL_W    = OFFSET_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      REFILL
   } state_t;

   // CPU byte address viewed as its cache fields (MSB first).
   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [INDEX_W-1:0] index;
      logic [WSEL_W-1:0]  wsel;
      logic [1:0]         byte_off;
   } addr_fields_t;

   function automatic addr_fields_t split_addr(input logic [31:0] addr);
      return addr_fields_t'(addr);
   endfunction

   // Line-aligned memory address for a given tag/index pair.
   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                             input logic [INDEX_W-1:0] index);
      return {tag, index, {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Per-line storage: valid/dirty flags, tags and line data, read combinationally at one index.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [INDEX_W-1:0]   index,
   output logic                 valid,
   output logic                 dirty,
   output logic [TAG_W-1:0]     tag,
   output logic [LINE_BITS-1:0] line,
   input  logic                 word_we,
   input  logic [WSEL_W-1:0]    word_sel,
   input  logic [31:0]          word_data,
   input  logic                 line_we,
   input  logic [TAG_W-1:0]     line_tag,
   input  logic [LINE_BITS-1:0] line_data
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   // Status flags: cleared asynchronously, set by a line install or a word store.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data arrays: full-line install on refill, single-word merge on a store hit.
   always_ff @(posedge clk_i) begin
      // NOTE: the arrays carry no reset; the valid flag qualifies them, which keeps them RAM-mappable.
      if (line_we) begin
         tag_q[index]  <= line_tag;
         data_q[index] <= line_data;
      end else if (word_we) begin
         data_q[index][word_sel*32 +: 32] <= word_data;
      end
   end

   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag   = tag_q[index];
   assign line  = data_q[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and line-wide memory.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i
);

   state_t               state;
   state_t               state_next;
   addr_fields_t         req;
   logic [INDEX_W-1:0]   miss_index;
   logic [TAG_W-1:0]     miss_tag;
   logic [INDEX_W-1:0]   arr_index;
   logic                 line_valid;
   logic                 line_dirty;
   logic [TAG_W-1:0]     line_tag;
   logic [LINE_BITS-1:0] line_data;
   logic                 hit;
   logic                 word_we;
   logic                 line_we;
   logic                 capture_miss;
   logic                 unused_byte_off;

   assign req             = split_addr(cpu_addr_i);
   assign unused_byte_off = ^req.byte_off;

   // While a transfer is in flight the arrays follow the latched miss index, so the victim
   // line and the install slot stay fixed even if the CPU side drops or changes its request.
   assign arr_index = (state == IDLE) ? req.index : miss_index;
   assign hit       = line_valid && (line_tag == req.tag);

   dcache_sram u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .index     (arr_index),
      .valid     (line_valid),
      .dirty     (line_dirty),
      .tag       (line_tag),
      .line      (line_data),
      .word_we   (word_we),
      .word_sel  (req.wsel),
      .word_data (cpu_wdata_i),
      .line_we   (line_we),
      .line_tag  (miss_tag),
      .line_data (mem_rdata_i)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_next;
   end

   // Latch the missing address so memory address and install slot are stable for the whole miss.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         miss_index <= '0;
         miss_tag   <= '0;
      end else if (capture_miss) begin
         miss_index <= req.index;
         miss_tag   <= req.tag;
      end
   end

   // Next state, CPU-side responses and memory handshake.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next   = state;
      cpu_stall_o  = 1'b0;
      cpu_rdata_o  = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      word_we      = 1'b0;
      line_we      = 1'b0;
      capture_miss = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  if (cpu_we_i) word_we     = 1'b1;
                  else          cpu_rdata_o = line_data[req.wsel*32 +: 32];
               end else begin
                  cpu_stall_o  = 1'b1;
                  capture_miss = 1'b1;
                  state_next   = (line_valid && line_dirty) ? WB : REFILL;
               end
            end
         end
         WB: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = line_addr(line_tag, miss_index);
            mem_wdata_o = line_data;
            if (mem_ack_i) state_next = REFILL;
         end
         REFILL: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = line_addr(miss_tag, miss_index);
            if (mem_ack_i) begin
               line_we    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a line-level cache model.
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         cpu_req;
   logic         cpu_we;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [127:0] mem_wdata_o;
   logic [127:0] mem_rdata_i;
   logic         mem_ack_i;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dcache_controller dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   // Reference model: 16 lines of 4 words, 24-bit tags, plus a sparse main memory.
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [23:0]  m_tag   [16];
   logic [31:0]  m_word  [16][4];
   logic [127:0] main_mem [logic [31:0]];

   typedef struct {
      bit           we;
      logic [31:0]  addr;
      logic [127:0] data;
   } xfer_t;
   xfer_t exp_q[$];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      if (main_mem.exists(a)) return main_mem[a];
      return {a ^ 32'h0F0F_0003, a ^ 32'h5A5A_0002, a ^ 32'hA5A5_0001, a ^ 32'hC3C3_0000};
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 16; k++) begin
         m_valid[k] = 1'b0;
         m_dirty[k] = 1'b0;
      end
   endfunction

   // One CPU access: predict transfers, stall length and load data, then drive it and
   // act as the memory (lat idle request cycles before the one-cycle ack).
   task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input int lat, input bit drop, input string tag);
      logic [3:0]   idx;
      logic [23:0]  t;
      logic [1:0]   w;
      bit           hit;
      int           exp_stall;
      logic [31:0]  exp_rd;
      logic [127:0] ln;
      xfer_t        x;
      int           stalls;
      int           cycles;
      int           wait_cnt;
      idx = addr[7:4];
      t   = addr[31:8];
      w   = addr[3:2];
      hit = m_valid[idx] && (m_tag[idx] == t);
      exp_q.delete();
      if (!hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            ln = {m_word[idx][3], m_word[idx][2], m_word[idx][1], m_word[idx][0]};
            x.we = 1'b1; x.addr = {m_tag[idx], idx, 4'h0}; x.data = ln;
            main_mem[x.addr] = ln;
            exp_q.push_back(x);
         end
         ln = mem_line({t, idx, 4'h0});
         x.we = 1'b0; x.addr = {t, idx, 4'h0}; x.data = ln;
         exp_q.push_back(x);
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = t;
         for (int k = 0; k < 4; k++) m_word[idx][k] = ln[k*32 +: 32];
      end
      exp_stall = hit ? 0 : 1 + exp_q.size() * (lat + 1);
      if (we && !(drop && !hit)) begin
         m_word[idx][w] = wd;
         m_dirty[idx]   = 1'b1;
      end
      exp_rd = m_word[idx][w];

      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      stalls = 0; cycles = 0; wait_cnt = 0;
      #1;
      while (cpu_stall_o === 1'b1 && cycles < 300) begin
         stalls++;
         if (drop && stalls == 2) begin
            cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
         end
         if (mem_req_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check({tag, "_unexp_req"}, mem_req_o, 0);
               mem_ack_i = 1'b1;
            end else begin
               check({tag, "_mem_we"}, mem_we_o, exp_q[0].we);
               check({tag, "_mem_addr"}, mem_addr_o, exp_q[0].addr);
               if (exp_q[0].we) check({tag, "_mem_wdata"}, mem_wdata_o, exp_q[0].data);
               if (wait_cnt == lat) begin
                  mem_ack_i   = 1'b1;
                  mem_rdata_i = exp_q[0].we ? {$urandom, $urandom, $urandom, $urandom} : exp_q[0].data;
                  void'(exp_q.pop_front());
                  wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
         end
         @(negedge clk);
         mem_ack_i = 1'b0;
         #1;
         cycles++;
      end
      check({tag, "_no_timeout"}, cycles < 300, 1);
      check({tag, "_stall_cycles"}, stalls, exp_stall);
      check({tag, "_xfers_left"}, exp_q.size(), 0);
      check({tag, "_req_done"}, mem_req_o, 0);
      if (!we && !drop) check({tag, "_rdata"}, cpu_rdata_o, exp_rd);
   endtask

   initial begin
      logic [31:0] a;
      rst_i = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      main_mem[32'h40] = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'h1111_1111, 32'hCAFE_0000};
      model_reset();

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", cpu_stall_o, 0);
      check("rst_mem_req", mem_req_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      check("rst_rdata", cpu_rdata_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      @(negedge clk);
      rst_i = 1'b1;

      // Cold load, hits, store hit, dirty conflict, re-fetch of written-back line.
      access(1'b0, 32'h0000_0040, 32'h0, 5, 1'b0, "cold_ld40");
      check("cold_ld40_word0", cpu_rdata_o, 32'hCAFE_0000);
      access(1'b0, 32'h0000_0044, 32'h0, 5, 1'b0, "hit_ld44");
      check("hit_ld44_word1", cpu_rdata_o, 32'h1111_1111);
      access(1'b1, 32'h0000_0048, 32'h1234_5678, 5, 1'b0, "st_hit48");
      access(1'b0, 32'h0000_0048, 32'h0, 5, 1'b0, "ld48");
      check("ld48_value", cpu_rdata_o, 32'h1234_5678);
      access(1'b0, 32'h0000_0140, 32'h0, 5, 1'b0, "conflict_ld140");
      access(1'b0, 32'h0000_0048, 32'h0, 2, 1'b0, "refetch_ld48");
      check("refetch_ld48_value", cpu_rdata_o, 32'h1234_5678);
      access(1'b0, 32'h0000_0140, 32'h0, 1, 1'b0, "again_ld140");

      // Store miss to a clean slot: refill only, then merge.
      access(1'b1, 32'h0000_0088, 32'hBEEF_0001, 3, 1'b0, "st_miss88");
      for (int k = 0; k < 4; k++) begin
         a = 32'h80 + 32'(k * 4);
         access(1'b0, a, 32'h0, 3, 1'b0, "ld8x");
      end

      // Highest index, request dropped mid-miss: the line is still installed, the store is not.
      access(1'b1, 32'h0000_02F4, 32'hDEAD_DEAD, 2, 1'b1, "drop_stF4");
      access(1'b0, 32'h0000_02F4, 32'h0, 2, 1'b0, "after_drop_ldF4");

      // Reset in the middle of a refill.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300;
      @(negedge clk);
      #1;
      check("mid_refill_req", mem_req_o, 1);
      #2;
      rst_i = 1'b0; cpu_req = 1'b0;
      #1;
      check("async_rst_req", mem_req_o, 0);
      check("async_rst_stall", cpu_stall_o, 0);
      check("async_rst_addr", mem_addr_o, 0);
      @(negedge clk);
      rst_i = 1'b1;
      model_reset();
      access(1'b0, 32'h0000_0140, 32'h0, 2, 1'b0, "post_rst_ld140");
      access(1'b0, 32'h0000_0088, 32'h0, 2, 1'b0, "post_rst_ld88");

      // Spurious ack while idle.
      @(negedge clk);
      cpu_req = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("spur_ack_req", mem_req_o, 0);
      check("spur_ack_stall", cpu_stall_o, 0);
      @(negedge clk);
      mem_ack_i = 1'b0;
      access(1'b0, 32'h0000_0144, 32'h0, 2, 1'b0, "post_spur_ld144");
      access(1'b0, 32'h0000_008C, 32'h0, 2, 1'b0, "post_spur_ld8C");

      // Random traffic over four tags so conflicts and write-backs are frequent.
      for (int i = 0; i < 250; i++) begin
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0), "rnd");
      end

      @(negedge clk);
      cpu_req = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage (Data_Memory port) and a multi-cycle line-wide main memory.
- Hits complete in the MEM cycle with no stall; misses raise cpu_stall_o, freezing the whole pipeline until the line is resident.
- The CPU drives a word-granular load/store request; the cache drives a request/acknowledge handshake to memory.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, ≥2.
- LINE_BITS, 128, line width in bits (4 words); memory transfer width.
- OFFSET_W, 4, byte-offset bits = log2(LINE_BITS/8).
- INDEX_W, 4, log2(NUM_LINES).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- cpu_req_i  in  1  MEM stage holds a load or store (MemRead|MemWrite).
- cpu_we_i  in  1  1=store, 0=load.
- cpu_addr_i  in  32  byte address; bits[1:0] ignored (word-aligned).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i & !cpu_we_i & !cpu_stall_o.
- cpu_stall_o  out  1  pipeline freeze.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  1=line write-back, 0=line fetch.
- mem_addr_o  out  32  line-aligned address (low OFFSET_W bits zero).
- mem_wdata_o  out  LINE_BITS  victim line for write-back.
- mem_rdata_i  in  LINE_BITS  fetched line, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: offset=addr[OFFSET_W-1:0], word select=addr[OFFSET_W-1:2], index=addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag=remaining upper bits.
- Storage per line: valid, dirty, tag, LINE_BITS data.
- hit = valid[index] & (tag match).
- Reset (rst_i=0, async):
  - all valid and dirty cleared; state=IDLE.
  - mem_req_o=0, mem_we_o=0, cpu_stall_o=0, cpu_rdata_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-miss aborts the transfer; dirty data is discarded.
- FSM states: IDLE, WB, REFILL.
- IDLE:
  - cpu_stall_o = cpu_req_i & !hit (combinational).
  - Read hit: cpu_rdata_o = selected word, same cycle, zero added latency.
  - Write hit: word written and dirty set at the clock edge.
  - Miss with victim valid & dirty: go to WB. Otherwise go to REFILL.
- WB:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 0}, mem_wdata_o=victim line; cpu_stall_o=1.
  - On mem_ack_i: go to REFILL.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 0}; cpu_stall_o=1.
  - On mem_ack_i: line=mem_rdata_i, tag updated, valid=1, dirty=0; go to IDLE.
- After REFILL, IDLE re-evaluates and hits:
  - A store then merges its word and sets dirty.
  - Miss penalty = memory latency + 1 cycle (clean); two memory latencies + 1 (dirty).
- The CPU holds cpu_* inputs stable while cpu_stall_o=1.
- mem_ack_i in IDLE is ignored.
- cpu_req_i dropping during WB/REFILL does not abort the transfer; the line is still installed.
- mem_addr_o and mem_wdata_o are stable throughout a request; mem_req_o deasserts the cycle after ack.
- Index wrap: the highest index maps like any other; no cross-line access exists (word-aligned).
- No replacement choice (direct-mapped); the victim is always line[index].

Decomposition:
- Shared package dcache_pkg: state enum (IDLE, WB, REFILL), derived widths TAG_W = 32-INDEX_W-OFFSET_W and WORDS = LINE_BITS/32, address-field extraction functions.
- One natural sub-module, dcache_sram: tag/valid/dirty/data arrays with async-clear valid/dirty, combinational read, and word-merge or full-line write.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
- Cold load 0x0000_0040, memory returns line {D3,D2,D1,0xCAFE_0000} after 5 cycles:
  - mem_req_o=1, we=0, addr=0x40; stall lasts 7 cycles.
  - cpu_rdata_o=0xCAFE_0000; the next load to 0x44 returns D1 with no stall.
- Store 0x1234_5678 to 0x48 (line resident):
  - no stall; dirty set.
  - A load of 0x48 the next cycle returns 0x1234_5678.
- Conflict load to 0x0000_0140 (same index 4, dirty victim):
  - WB first, with addr=0x40 and wdata word2=0x1234_5678.
  - Then REFILL at addr=0x140; dirty=0 afterwards.
- Store miss to clean line 0x80:
  - REFILL only, no WB.
  - The store merges after refill; other words equal the memory data; dirty=1.
- Assert rst_i=0 during REFILL:
  - mem_req_o drops immediately (async).
  - After release, a load to the previously resident 0x140 misses again.
- Spurious mem_ack_i in IDLE with no request:
  - no state change; valid/dirty/data unchanged.
